bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 88 ++++++++
 tb/tb_bit_serializer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial shifter with a one-word hold buffer for gapless streaming
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sh, sh_n, hold, hold_n, shifted;
    logic             hold_full, hold_full_n;
    logic             xfer, last;

    // The bit on the wire always sits at one end of the shift register, so the
    // serial outputs depend only on registered state.
    assign shifted   = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
    assign din_ready = !hold_full;
    assign xfer      = din_valid && din_ready;
    assign last      = cnt == LAST;
    assign busy      = state == SHIFT;
    assign ser_valid = busy;
    assign word_done = busy && last;
    assign ser_out   = busy ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : IDLE_BIT;

    // Next-state: load on idle transfer, shift mid-word, refill from hold or din at the word boundary
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        sh_n        = sh;
        hold_n      = hold;
        hold_full_n = hold_full;
        if (state == IDLE) begin
            if (xfer) begin
                sh_n    = din;
                cnt_n   = '0;
                state_n = SHIFT;
            end
        end else if (!last) begin
            sh_n  = shifted;
            cnt_n = cnt + 1'b1;
            if (xfer) begin
                hold_n      = din;
                hold_full_n = 1'b1;
            end
        end else if (hold_full) begin
            sh_n        = hold;
            hold_full_n = 1'b0;
            cnt_n       = '0;
        end else if (xfer) begin
            sh_n  = din;
            cnt_n = '0;
        end else begin
            cnt_n   = '0;
            state_n = IDLE;
        end
    end

    // State register; reset discards any word in flight or held
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sh        <= sh_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed checks of the serializer, MSB-first and LSB-first instances
module tb_bit_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0, l_din = '0;
    logic       din_valid = 1'b0, l_din_valid = 1'b0;
    logic       din_ready, ser_out, ser_valid, word_done, busy;
    logic       l_din_ready, l_ser_out, l_ser_valid, l_word_done, l_busy;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .ser_out(ser_out), .ser_valid(ser_valid), .word_done(word_done), .busy(busy)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(l_din), .din_valid(l_din_valid), .din_ready(l_din_ready),
        .ser_out(l_ser_out), .ser_valid(l_ser_valid), .word_done(l_word_done), .busy(l_busy)
    );

    task automatic test_reset;
        din = 8'hAA;
        din_valid = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({ser_out, ser_valid, word_done, busy, din_ready} !== 5'b00001) begin
                errors++;
                $display("FAIL reset cyc%0d: out/valid/done/busy/ready=%b required 00001", i,
                         {ser_out, ser_valid, word_done, busy, din_ready});
            end
        end
        din_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ser_out, ser_valid, busy, din_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_release: out/valid/busy/ready=%b required 0001",
                     {ser_out, ser_valid, busy, din_ready});
        end
    endtask

    task automatic test_single;
        logic [7:0] w = 8'b11011000;
        logic [2:0] det = 3'b000;
        int         hits = 0;
        din = w;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({ser_valid, ser_out, word_done, busy} !== {1'b1, w[7-i], i == 7, 1'b1}) begin
                errors++;
                $display("FAIL single bit%0d: valid/out/done/busy=%b required %b", i,
                         {ser_valid, ser_out, word_done, busy}, {1'b1, w[7-i], i == 7, 1'b1});
            end
            if (ser_valid) begin
                det = {det[1:0], ser_out};
                if (det == 3'b110) hits++;
            end
            @(negedge clk);
        end
        checks++;
        if ({ser_valid, ser_out, busy, word_done} !== 4'b0000) begin
            errors++;
            $display("FAIL single_idle: valid/out/busy/done=%b required 0000",
                     {ser_valid, ser_out, busy, word_done});
        end
        checks++;
        if (hits != 2) begin
            errors++;
            $display("FAIL single_detect: pulses=%0d required 2", hits);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] s = {8'hC3, 8'h5A};
        din = 8'hC3;
        din_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            if (i == 0) din = 8'h5A;
            if (i == 1) din_valid = 1'b0;
            checks++;
            if ({ser_valid, ser_out, word_done, din_ready} !==
                {1'b1, s[15-i], i == 7 || i == 15, !(i >= 1 && i <= 7)}) begin
                errors++;
                $display("FAIL b2b bit%0d: valid/out/done/ready=%b required %b", i,
                         {ser_valid, ser_out, word_done, din_ready},
                         {1'b1, s[15-i], i == 7 || i == 15, !(i >= 1 && i <= 7)});
            end
            @(negedge clk);
        end
        checks++;
        if ({ser_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle: valid/busy=%b required 00", {ser_valid, busy});
        end
    endtask

    task automatic test_bypass;
        logic [15:0] s = {8'hA5, 8'hF0};
        din = 8'hA5;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 7) begin
                din = 8'hF0;
                din_valid = 1'b1;
            end
            if (i == 8) din_valid = 1'b0;
            checks++;
            if ({ser_valid, ser_out, word_done, din_ready} !==
                {1'b1, s[15-i], i == 7 || i == 15, 1'b1}) begin
                errors++;
                $display("FAIL bypass bit%0d: valid/out/done/ready=%b required %b", i,
                         {ser_valid, ser_out, word_done, din_ready},
                         {1'b1, s[15-i], i == 7 || i == 15, 1'b1});
            end
            @(negedge clk);
        end
        checks++;
        if ({ser_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL bypass_idle: valid/busy=%b required 00", {ser_valid, busy});
        end
    endtask

    task automatic test_lsb;
        logic [7:0] e = 8'b01100000;
        l_din = 8'b00000110;
        l_din_valid = 1'b1;
        @(negedge clk);
        l_din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({l_ser_valid, l_ser_out, l_word_done} !== {1'b1, e[7-i], i == 7}) begin
                errors++;
                $display("FAIL lsb bit%0d: valid/out/done=%b required %b", i,
                         {l_ser_valid, l_ser_out, l_word_done}, {1'b1, e[7-i], i == 7});
            end
            @(negedge clk);
        end
        checks++;
        if ({l_ser_valid, l_ser_out, l_busy} !== 3'b000) begin
            errors++;
            $display("FAIL lsb_idle: valid/out/busy=%b required 000",
                     {l_ser_valid, l_ser_out, l_busy});
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        din = 8'hFF;
        din_valid = 1'b1;
        @(negedge clk);
        din = 8'h0F;
        @(negedge clk);
        din_valid = 1'b0;
        checks++;
        if (din_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_held: ready=%b required 0", din_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ser_valid, ser_out, busy, din_ready, word_done} !== 5'b00010) begin
            errors++;
            $display("FAIL rstmid: valid/out/busy/ready/done=%b required 00010",
                     {ser_valid, ser_out, busy, din_ready, word_done});
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ser_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rstmid_resume: valid cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_stall;
        logic [23:0] s = {8'h96, 8'h3C, 8'hE1};
        logic        rdy;
        din = 8'h96;
        din_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            if (i == 0) din = 8'h3C;
            if (i == 1) din = 8'hE1;
            if (i == 9) din_valid = 1'b0;
            rdy = (i == 0) || (i == 8) || (i >= 16);
            checks++;
            if ({ser_valid, ser_out, word_done, din_ready} !==
                {1'b1, s[23-i], i == 7 || i == 15 || i == 23, rdy}) begin
                errors++;
                $display("FAIL stall bit%0d: valid/out/done/ready=%b required %b", i,
                         {ser_valid, ser_out, word_done, din_ready},
                         {1'b1, s[23-i], i == 7 || i == 15 || i == 23, rdy});
            end
            @(negedge clk);
        end
        checks++;
        if ({ser_valid, busy, din_ready} !== 3'b001) begin
            errors++;
            $display("FAIL stall_idle: valid/busy/ready=%b required 001",
                     {ser_valid, busy, din_ready});
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_bypass;
        test_lsb;
        test_reset_mid;
        test_stall;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
